ttt_turn_ctrl: RTL and testbench
================================

Name: ttt_turn_ctrl

Overview:
- Turn sequencer for the tic-tac-toe board register bank: nine 2-bit position registers, each with its own write enable and a shared playerID bus.
- Accepts move requests and rejects illegal ones.
- Drives exactly one box enable per legal move, alternates players and enforces a per-turn timeout.
- Detects win/draw from the bank's pos outputs; the board is cleared through a board_clr strobe that the top level ORs into the bank reset.

Parameters:
- TIMEOUT_CYCLES, 50000000, cycles allowed per turn before forfeit (1 s at 50 MHz); must be >= 2.
- FIRST_PLAYER, 2'b01, playerID that moves first after start; legal values 2'b01 or 2'b10.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  level; begins a new game when sampled in IDLE or DONE.
- move_valid  in  1  one-cycle move request.
- move_sel  in  4  box number 1..9; 0 and 10..15 are illegal.
- pos1..pos9  in  2 each  board contents from the bank; 00 empty, 01 P1, 10 P2.
- playerID  out  2  player to move; also the bank write data.
- en  out  9  box write enables; bit k-1 drives box k; one-hot or zero.
- board_clr  out  1  one-cycle clear pulse to the bank.
- illegal  out  1  one-cycle pulse on a rejected move.
- timeout  out  1  one-cycle pulse on a forfeited turn.
- game_over  out  1  high in DONE.
- winner  out  2  00 none/draw, 01 or 10 winning player; valid while game_over.
- move_count  out  4  legal moves placed this game, 0..9.

Behaviour:
- All outputs registered. Reset (synchronous, active-high) has priority over everything and puts the block in IDLE with: playerID=FIRST_PLAYER, en=0, board_clr=0, illegal=0, timeout=0, game_over=0, winner=00, move_count=0, timer=TIMEOUT_CYCLES-1.
- States: IDLE, CLEAR, WAIT_MOVE, WRITE, CHECK, DONE.
- IDLE: start=1 -> CLEAR, board_clr=1 for that one cycle.
- CLEAR: playerID=FIRST_PLAYER, move_count=0, winner=00, timer reloaded; -> WAIT_MOVE.
- WAIT_MOVE:
  - Timer decrements every cycle.
  - On move_valid=1:
    - If move_sel is in 1..9 and pos[move_sel]==00: next cycle en[move_sel-1]=1; -> WRITE.
    - Otherwise: illegal=1 next cycle; stay in WAIT_MOVE; the timer keeps running.
  - Timer==0 with no move_valid: timeout=1 next cycle, playerID toggles (01<->10), timer reloads, move_count unchanged.
  - Timer==0 with move_valid in the same cycle: the move wins. A legal move is taken; an illegal move gives illegal=1 and timeout=1 together, with the toggle.
- WRITE: en is high for exactly this one cycle and the bank captures playerID at its end; move_count increments; -> CHECK. move_valid is ignored in WRITE and CHECK.
- CHECK: evaluates the 8 lines (rows 123/456/789, columns 147/258/369, diagonals 159/357) for three boxes equal to playerID.
  - Win -> DONE, winner=playerID.
  - Else move_count==9 -> DONE, winner=00.
  - Else toggle playerID, reload timer -> WAIT_MOVE.
- Latency: a legal request at cycle t gives en at t+1, the bank updates at end of t+1, and CHECK happens at t+2. The next request is accepted from t+3.
- DONE: game_over=1; holds winner, move_count and playerID; timer halted. start=1 -> CLEAR with board_clr pulse; game_over drops in the CLEAR cycle.
- start is ignored in WAIT_MOVE, WRITE and CHECK (no mid-game restart except via reset).
- Reset mid-WRITE: en drops on the reset cycle. The bank's own reset clears the board.
- Invariants: en never has more than one bit set; en and board_clr are never high in the same cycle.

Test Plan:
- Reset, start=1 -> board_clr pulse one cycle; playerID=01; WAIT_MOVE; move_count=0.
- P1 plays 1, P2 plays 4, P1 plays 2, P2 plays 5, P1 plays 3 -> en one-hot per move (0x001, 0x008, 0x002, 0x010, 0x004); game_over=1, winner=01, move_count=5; further move_valid ignored.
- P1 plays 5, then P2 requests 5, then P2 requests move_sel=0 and move_sel=12 -> illegal pulses each time, en=0, playerID stays 10, move_count=1.
- TIMEOUT_CYCLES=8, no request after start -> timeout pulse 8 cycles after entering WAIT_MOVE; playerID 01->10; en never asserted.
- Move sequence 1,2,3,5,4,6,8,7,9 -> no line completed; DONE with winner=00, move_count=9.
- Reset asserted in the WRITE cycle -> next cycle IDLE, en=0, all outputs at reset values. In DONE, start=1 -> board_clr pulse and a new game with playerID=FIRST_PLAYER.

Source files
------------

// File: rtl/ttt_turn_ctrl.sv
// ttt_turn_ctrl: tic-tac-toe turn sequencer driving a 9-box board register bank
// Ports: clock/reset (sync, active-high); start, move_valid, move_sel[3:0] requests;
// pos1..pos9 board contents from the bank; playerID/en[8:0] bank write controls;
// board_clr, illegal, timeout pulses; game_over, winner[1:0], move_count[3:0] status.
module ttt_turn_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter logic [1:0] FIRST_PLAYER = 2'b01
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       move_valid,
  input  logic [3:0] move_sel,
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  input  logic [1:0] pos3,
  input  logic [1:0] pos4,
  input  logic [1:0] pos5,
  input  logic [1:0] pos6,
  input  logic [1:0] pos7,
  input  logic [1:0] pos8,
  input  logic [1:0] pos9,
  output logic [1:0] playerID,
  output logic [8:0] en,
  output logic       board_clr,
  output logic       illegal,
  output logic       timeout,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [3:0] move_count
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] RELOAD = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, CLEAR, WAIT_MOVE, WRITE, CHECK, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] player_q, player_d, winner_q, winner_d;
  logic [8:0] en_q, en_d;
  logic [3:0] count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic clr_q, clr_d, illegal_q, illegal_d, timeout_q, timeout_d, over_q, over_d;
  logic [8:0][1:0] b;
  logic [8:0] empty, mine, sel_oh;
  logic legal, win;
  assign b = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
  for (genvar i = 0; i < 9; i++) begin : g_box
    assign empty[i] = b[i] == 2'b00;
    assign mine[i] = b[i] == player_q;
  end
  // move_sel of 0 or 10..15 shifts the bit out of the 9-bit window, so it can never be legal
  assign sel_oh = 9'b1 << (move_sel - 4'd1);
  assign legal = |(sel_oh & empty);
  assign win = (mine[0] & mine[1] & mine[2]) | (mine[3] & mine[4] & mine[5]) |
               (mine[6] & mine[7] & mine[8]) | (mine[0] & mine[3] & mine[6]) |
               (mine[1] & mine[4] & mine[7]) | (mine[2] & mine[5] & mine[8]) |
               (mine[0] & mine[4] & mine[8]) | (mine[2] & mine[4] & mine[6]);
  always_comb begin
    state_d = state_q;
    player_d = player_q;
    winner_d = winner_q;
    count_d = count_q;
    timer_d = timer_q;
    en_d = '0;
    clr_d = 1'b0;
    illegal_d = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = start ? CLEAR : state_q;
        clr_d = start;
      end
      CLEAR: begin
        state_d = WAIT_MOVE;
        player_d = FIRST_PLAYER;
        winner_d = 2'b00;
        count_d = '0;
        timer_d = RELOAD;
      end
      WAIT_MOVE: begin
        timer_d = timer_q - 1'b1;
        if (move_valid && legal) begin
          state_d = WRITE;
          en_d = sel_oh;
        end else begin
          illegal_d = move_valid;
          if (timer_q == '0) begin
            timeout_d = 1'b1;
            player_d = player_q ^ 2'b11;
            timer_d = RELOAD;
          end
        end
      end
      WRITE: begin
        state_d = CHECK;
        count_d = count_q + 4'd1;
      end
      CHECK: begin
        state_d = (win || count_q == 4'd9) ? DONE : WAIT_MOVE;
        winner_d = win ? player_q : 2'b00;
        player_d = (win || count_q == 4'd9) ? player_q : player_q ^ 2'b11;
        timer_d = RELOAD;
      end
      default: state_d = IDLE;
    endcase
    over_d = state_d == DONE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      player_q <= FIRST_PLAYER;
      winner_q <= 2'b00;
      count_q <= '0;
      timer_q <= RELOAD;
      en_q <= '0;
      clr_q <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      over_q <= 1'b0;
    end else begin
      state_q <= state_d;
      player_q <= player_d;
      winner_q <= winner_d;
      count_q <= count_d;
      timer_q <= timer_d;
      en_q <= en_d;
      clr_q <= clr_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      over_q <= over_d;
    end
  end
  assign playerID = player_q;
  assign en = en_q;
  assign board_clr = clr_q;
  assign illegal = illegal_q;
  assign timeout = timeout_q;
  assign game_over = over_q;
  assign winner = winner_q;
  assign move_count = count_q;
endmodule

// File: tb/tb_ttt_turn_ctrl.sv
// tb_ttt_turn_ctrl: directed self-checking bench with a behavioural board bank
module tb_ttt_turn_ctrl;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, move_valid = 1'b0;
  logic [3:0] move_sel = 4'd0;
  logic [8:0][1:0] bank;
  logic [1:0] playerID, winner;
  logic [8:0] en;
  logic board_clr, illegal, timeout, game_over;
  logic [3:0] move_count;
  int n_chk = 0, n_fail = 0;
  always #5 clock = ~clock;
  ttt_turn_ctrl #(.TIMEOUT_CYCLES(8), .FIRST_PLAYER(2'b01)) dut (
    .clock(clock), .reset(reset), .start(start), .move_valid(move_valid), .move_sel(move_sel),
    .pos1(bank[0]), .pos2(bank[1]), .pos3(bank[2]), .pos4(bank[3]), .pos5(bank[4]),
    .pos6(bank[5]), .pos7(bank[6]), .pos8(bank[7]), .pos9(bank[8]),
    .playerID(playerID), .en(en), .board_clr(board_clr), .illegal(illegal), .timeout(timeout),
    .game_over(game_over), .winner(winner), .move_count(move_count)
  );
  always_ff @(posedge clock) begin
    for (int k = 0; k < 9; k++)
      bank[k] <= (reset || board_clr) ? 2'b00 : en[k] ? playerID : bank[k];
  end
  always @(negedge clock) begin
    if (!reset) begin
      n_chk++;
      assert ($countones(en) <= 1 && !(en != 0 && board_clr)) else begin
        n_fail++;
        $error("FAIL invariant: en=%0h board_clr=%0b required onehot-or-zero and exclusive", en, board_clr);
      end
    end
  end
  task automatic step(int k = 1);
    repeat (k) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic play(logic [3:0] s, logic [15:0] exp_en);
    move_valid = 1'b1;
    move_sel = s;
    step();
    move_valid = 1'b0;
    chk("move_en", en, exp_en);
    step();
    chk("en_one_cycle", en, 0);
    step();
  endtask
  task automatic new_game();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("board_clr_pulse", board_clr, 1);
    chk("over_drop_in_clear", game_over, 0);
    step();
    chk("board_clr_off", board_clr, 0);
    chk("first_player", playerID, 2'b01);
    chk("count_zero", move_count, 0);
    chk("winner_clear", winner, 0);
  endtask
  initial begin
    step(2);
    chk("rst_player", playerID, 2'b01);
    chk("rst_en", en, 0);
    chk("rst_clr", board_clr, 0);
    chk("rst_over", game_over, 0);
    chk("rst_winner", winner, 0);
    chk("rst_count", move_count, 0);
    reset = 1'b0;
    step();
    chk("idle_no_clr", board_clr, 0);
    new_game();
    play(4'd1, 16'h001);
    chk("g1_p2", playerID, 2'b10);
    play(4'd4, 16'h008);
    chk("g1_p1", playerID, 2'b01);
    play(4'd2, 16'h002);
    play(4'd5, 16'h010);
    play(4'd3, 16'h004);
    chk("g1_over", game_over, 1);
    chk("g1_winner", winner, 2'b01);
    chk("g1_count", move_count, 5);
    chk("g1_player_held", playerID, 2'b01);
    move_valid = 1'b1;
    move_sel = 4'd9;
    step();
    move_valid = 1'b0;
    chk("done_ignore_en", en, 0);
    chk("done_ignore_illegal", illegal, 0);
    step();
    chk("done_count_held", move_count, 5);
    chk("done_over_held", game_over, 1);
    new_game();
    play(4'd5, 16'h010);
    chk("g2_p2", playerID, 2'b10);
    move_valid = 1'b1;
    move_sel = 4'd5;
    step();
    chk("occupied_illegal", illegal, 1);
    chk("occupied_en", en, 0);
    move_sel = 4'd0;
    step();
    chk("sel0_illegal", illegal, 1);
    chk("sel0_en", en, 0);
    move_sel = 4'd12;
    step();
    move_valid = 1'b0;
    chk("sel12_illegal", illegal, 1);
    chk("sel12_en", en, 0);
    step();
    chk("illegal_pulse_end", illegal, 0);
    chk("g2_player_stays", playerID, 2'b10);
    chk("g2_count", move_count, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    new_game();
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("no_early_timeout", timeout, 0);
      chk("timeout_wait_en", en, 0);
    end
    chk("player_before_to", playerID, 2'b01);
    step();
    chk("timeout_pulse", timeout, 1);
    chk("timeout_toggle", playerID, 2'b10);
    chk("timeout_count", move_count, 0);
    step();
    chk("timeout_pulse_end", timeout, 0);
    step(6);
    chk("pre_coincide", timeout, 0);
    move_valid = 1'b1;
    move_sel = 4'd0;
    step();
    move_valid = 1'b0;
    chk("coincide_illegal", illegal, 1);
    chk("coincide_timeout", timeout, 1);
    chk("coincide_toggle", playerID, 2'b01);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    new_game();
    play(4'd1, 16'h001);
    play(4'd2, 16'h002);
    play(4'd3, 16'h004);
    play(4'd5, 16'h010);
    play(4'd4, 16'h008);
    play(4'd6, 16'h020);
    play(4'd8, 16'h080);
    play(4'd7, 16'h040);
    chk("draw_not_over", game_over, 0);
    play(4'd9, 16'h100);
    chk("draw_over", game_over, 1);
    chk("draw_winner", winner, 0);
    chk("draw_count", move_count, 9);
    new_game();
    move_valid = 1'b1;
    move_sel = 4'd1;
    step();
    move_valid = 1'b0;
    chk("write_en", en, 16'h001);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstw_en", en, 0);
    chk("rstw_player", playerID, 2'b01);
    chk("rstw_count", move_count, 0);
    chk("rstw_over", game_over, 0);
    chk("rstw_clr", board_clr, 0);
    chk("rstw_bank", bank[0], 0);
    new_game();
    play(4'd1, 16'h001);
    chk("after_rst_count", move_count, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
